// File: rtl/cla_pkg.sv
// Shared constants and FSM encoding for the multi-word add scheduler.
package cla_pkg;
    localparam int WW   = 16;
    localparam int MAXW = 4;
    localparam int OPW  = 64;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/cla_16bit.sv
// 16-bit carry-lookahead adder: four 4-bit groups with group generate/propagate.
module cla_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        // Group carries come from the lookahead terms, not from the bit chain.
        gc[0] = cin;
        for (int j = 0; j < 4; j++) begin
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
        for (int j = 0; j < 4; j++) begin
            c[4*j] = gc[j];
            for (int i = 0; i < 3; i++) begin
                c[4*j+i+1] = g[4*j+i] | (p[4*j+i] & c[4*j+i]);
            end
        end
        c[16] = gc[4];
        sum   = p ^ c[15:0];
        cout  = c[16];
    end
endmodule

// File: rtl/cla_add_sched.sv
// Round-robin scheduler sharing one cla_16bit across two requesters for
// multi-word adds, one 16-bit word per cycle with a registered carry chain.
module cla_add_sched #(
    parameter int NREQ = 2,
    parameter int WW   = 16,
    parameter int MAXW = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WW*MAXW-1:0] req_a,
    input  logic [NREQ*WW*MAXW-1:0] req_b,
    input  logic [NREQ*2-1:0]      req_len,
    input  logic [NREQ-1:0]        req_cin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [WW*MAXW-1:0]     rsp_sum,
    output logic                   rsp_cout
);
    import cla_pkg::ST_IDLE;
    import cla_pkg::ST_BUSY;
    import cla_pkg::ST_DONE;

    localparam int OPW = WW * MAXW;

    logic [1:0]     state;
    logic           last;
    logic           win;
    logic           grant;
    logic [1:0]     k;
    logic [1:0]     len_reg;
    logic           fin;
    logic           cin_reg;
    logic           carry_reg;
    logic [OPW-1:0] a_reg;
    logic [OPW-1:0] b_reg;
    logic [WW-1:0]  add_a;
    logic [WW-1:0]  add_b;
    logic [WW-1:0]  add_sum;
    logic           add_cin;
    logic           add_cout;

    // Handshakes: a transfer happens on an edge where valid and ready are both
    // high; req_ready is only ever raised in IDLE, rsp_valid only in DONE.
    always_comb begin
        win = req_valid[~last] ? ~last : last;
        grant = (state == ST_IDLE) && rst_n && req_valid[win];
        req_ready = '0;
        if (grant) req_ready[win] = 1'b1;
    end

    assign rsp_valid = (state == ST_DONE);
    assign add_a     = a_reg[32'(k)*WW +: WW];
    assign add_b     = b_reg[32'(k)*WW +: WW];
    assign add_cin   = (k == 2'd0) ? cin_reg : carry_reg;

    cla_16bit u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            last      <= 1'b1;
            k         <= 2'd0;
            fin       <= 1'b0;
            len_reg   <= 2'd0;
            cin_reg   <= 1'b0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        a_reg   <= req_a[32'(win)*OPW +: OPW];
                        b_reg   <= req_b[32'(win)*OPW +: OPW];
                        len_reg <= req_len[32'(win)*2 +: 2];
                        cin_reg <= req_cin[win];
                        rsp_id  <= win;
                        last    <= win;
                        rsp_sum <= '0;
                        k       <= 2'd0;
                        fin     <= 1'b0;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // After the last word one settle cycle passes before DONE.
                    if (fin) begin
                        fin   <= 1'b0;
                        k     <= 2'd0;
                        state <= ST_DONE;
                    end else begin
                        rsp_sum[32'(k)*WW +: WW] <= add_sum;
                        carry_reg <= add_cout;
                        k         <= k + 2'd1;
                        if (k == len_reg) begin
                            fin      <= 1'b1;
                            rsp_cout <= add_cout;
                        end
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
